// File: rtl/aes_pkg.sv
// Shared AES SubBytes constants, FSM state encoding and S-box tables.
// The inverse table exists only when SUBBYTES_INV_EN is defined.
package aes_pkg;

   localparam int BYTE_W   = 8;
   localparam int STATE_W  = 128;
   localparam int NB_BYTES = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_HOLD = 2'd2
   } sub_state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

`ifdef SUBBYTES_INV_EN
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box byte lookup; the inverse path and inv_i port exist only
// when SUBBYTES_INV_EN is defined.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [BYTE_W-1:0] byte_i,
`ifdef SUBBYTES_INV_EN
   input  logic              inv_i,
`endif
   output logic [BYTE_W-1:0] byte_o
);

   // Table lookup, direction chosen per transaction by the caller.
   always_comb begin
`ifdef SUBBYTES_INV_EN
      if (inv_i) begin
         byte_o = INV_SBOX[byte_i];
      end else begin
         byte_o = SBOX[byte_i];
      end
`else
      byte_o = SBOX[byte_i];
`endif
   end

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes: LANES shared S-boxes sweep the 16 state bytes over 16/LANES cycles.
// Define SUBBYTES_INV_EN to add the inv port (InvSubBytes per transaction).
module aes_subbytes_seq
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] inp,
`ifdef SUBBYTES_INV_EN
   input  logic               inv,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] res
);

   localparam int CYCLES = NB_BYTES / LANES;
   localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
      $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   sub_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [STATE_W-1:0] work_q;
   logic [STATE_W-1:0] work_d;
   logic [STATE_W-1:0] res_q;
   logic               out_valid_q;
`ifdef SUBBYTES_INV_EN
   logic               inv_q;
`endif

   logic [3:0]        base_s;
   logic [BYTE_W-1:0] lane_in_s  [LANES];
   logic [BYTE_W-1:0] lane_out_s [LANES];

   assign base_s = 4'(cnt_q * LANES);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [3:0] idx_s;
      assign idx_s        = base_s + 4'(l);
      assign lane_in_s[l] = work_q[{idx_s, 3'b000} +: BYTE_W];

      aes_sbox u_sbox (
         .byte_i (lane_in_s[l]),
`ifdef SUBBYTES_INV_EN
         .inv_i  (inv_q),
`endif
         .byte_o (lane_out_s[l])
      );
   end

   // Byte b is owned by lane b%LANES and rewritten only on sweep step b/LANES.
   for (genvar b = 0; b < NB_BYTES; b++) begin : g_byte
      assign work_d[BYTE_W*b +: BYTE_W] = (cnt_q == CNT_W'(b / LANES)) ? lane_out_s[b % LANES]
                                                                      : work_q[BYTE_W*b +: BYTE_W];
   end

   // In HOLD the stage can take a new state only when the current result is leaving.
   always_comb begin
      if (state_q == ST_IDLE) begin
         in_ready = 1'b1;
      end else if (state_q == ST_HOLD) begin
         in_ready = out_ready;
      end else begin
         in_ready = 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign res       = res_q;

   // Control FSM with lane counter, work register and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef SUBBYTES_INV_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  work_q  <= inp;
                  cnt_q   <= '0;
`ifdef SUBBYTES_INV_EN
                  inv_q   <= inv;
`endif
                  state_q <= ST_SUB;
               end
            end
            ST_SUB: begin
               work_q <= work_d;
               if (cnt_q == CNT_LAST) begin
                  res_q       <= work_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     work_q  <= inp;
                     cnt_q   <= '0;
`ifdef SUBBYTES_INV_EN
                     inv_q   <= inv;
`endif
                     state_q <= ST_SUB;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cnt_q       <= '0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq; reference S-box derived from GF(2^8) inversion
// plus the affine map. Exercises SUBBYTES_INV_EN cases when that macro is defined.
module tb_aes_subbytes_seq;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] inp;
   logic         inv_b;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] res;

   logic         x_iv  [4];
   logic         x_ir  [4];
   logic         x_ov  [4];
   logic [127:0] x_res [4];
   logic         x_or;

   int checks = 0;
   int errors = 0;

   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];

   aes_subbytes_seq #(.LANES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inp       (inp),
`ifdef SUBBYTES_INV_EN
      .inv       (inv_b),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res)
   );

   for (genvar g = 0; g < 4; g++) begin : g_x
      localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      aes_subbytes_seq #(.LANES(LN)) u_x (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (x_iv[g]),
         .in_ready  (x_ir[g]),
         .inp       (inp),
`ifdef SUBBYTES_INV_EN
         .inv       (1'b0),
`endif
         .out_valid (x_ov[g]),
         .out_ready (x_or),
         .res       (x_res[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [127:0] sub_state(input logic [127:0] d, input logic iv);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) begin
         r[8*k +: 8] = iv ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [127:0] d, input logic iv);
      int g = 0;
      inp = d; inv_b = iv; in_valid = 1'b1;
      while (!in_ready && g < 50) begin
         @(posedge clk); #1; g++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("accepted", {127'd0, (g < 50)}, 128'd1);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] d, e, pat, res_s;
      logic         iv, hs_in, hs_out;
      logic [7:0]   y, b;
      int           lat, sent, got, cyc;
      int           xlat [4];
      logic [127:0] xr   [4];
      int           xexp [4] = '{16, 8, 2, 1};
      logic [127:0] q [$];

      for (int x = 0; x < 256; x++) begin
         y = 8'h00;
         for (int z = 1; z < 256; z++) begin
            if (x != 0 && gmul(8'(x), 8'(z)) == 8'h01) y = 8'(z);
         end
         b = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
         fwd_t[x] = b;
      end
      for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inp = 128'd0; inv_b = 1'b0; x_or = 1'b1;
      for (int g = 0; g < 4; g++) x_iv[g] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_res", res, 128'd0);

      // Byte k = k through all other lane counts at once.
      pat = 128'h0F0E0D0C0B0A09080706050403020100;
      inp = pat;
      for (int g = 0; g < 4; g++) begin
         chk("x_in_ready", {127'd0, x_ir[g]}, 128'd1);
         x_iv[g] = 1'b1; xlat[g] = 0; xr[g] = 128'd0;
      end
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) x_iv[g] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            if (x_ov[g] && xlat[g] == 0) begin xlat[g] = c; xr[g] = x_res[g]; end
         end
      end
      for (int g = 0; g < 4; g++) begin
         chk("x_latency", 128'(xlat[g]), 128'(xexp[g]));
         chk("x_res", xr[g], 128'h76ABD7FE2B670130C56F6BF27B777C63);
      end

      accept(128'd0, 1'b0);
      wait_out(lat);
      chk("t1_latency", 128'(lat), 128'd4);
      chk("t1_res", res, {16{8'h63}});
      drain();
      chk("t1_drained", {127'd0, out_valid}, 128'd0);
      chk("t1_in_ready", {127'd0, in_ready}, 128'd1);

      accept(pat, 1'b0);
      wait_out(lat);
      chk("t2_latency", 128'(lat), 128'd4);
      chk("t2_res", res, 128'h76ABD7FE2B670130C56F6BF27B777C63);
      drain();

      // Stall in HOLD, then back-to-back release and reload.
      d = {$urandom, $urandom, $urandom, $urandom};
      e = sub_state(d, 1'b0);
      accept(d, 1'b0);
      wait_out(lat);
      for (int c = 0; c < 10; c++) begin
         chk("t3_hold_valid", {127'd0, out_valid}, 128'd1);
         chk("t3_hold_res", res, e);
         chk("t3_hold_in_ready", {127'd0, in_ready}, 128'd0);
         @(posedge clk); #1;
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      e = sub_state(d, 1'b0);
      out_ready = 1'b1; inp = d; in_valid = 1'b1;
      #1;
      chk("t3_b2b_in_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t3_b2b_valid_low", {127'd0, out_valid}, 128'd0);
      wait_out(lat);
      chk("t3_b2b_latency", 128'(lat), 128'd4);
      chk("t3_b2b_res", res, e);
      drain();

      // Reset while the sweep is at cnt=2; result register still holds the previous state.
      accept({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t4_out_valid", {127'd0, out_valid}, 128'd0);
      chk("t4_res", res, 128'd0);
      chk("t4_in_ready", {127'd0, in_ready}, 128'd1);
      rst_n = 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom};
      accept(d, 1'b0);
      wait_out(lat);
      chk("t4_latency", 128'(lat), 128'd4);
      chk("t4_res_after", res, sub_state(d, 1'b0));
      drain();

`ifdef SUBBYTES_INV_EN
      accept({16{8'h63}}, 1'b1);
      inv_b = 1'b0;
      wait_out(lat);
      chk("t5_inv_63", res, 128'd0);
      drain();
      accept({16{8'h53}}, 1'b1);
      wait_out(lat);
      chk("t5_inv_53", res, {16{8'h50}});
      drain();
      accept({16{8'h53}}, 1'b0);
      wait_out(lat);
      chk("t5_fwd_53", res, {16{8'hED}});
      drain();
`endif

      // Random throttled stream against the reference queue.
      sent = 0; got = 0; cyc = 0;
      in_valid = 1'b0; out_ready = 1'b0;
      while (got < 1000 && cyc < 40000) begin
         if (!in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
            d = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUBBYTES_INV_EN
            iv = 1'($urandom_range(0, 1));
`else
            iv = 1'b0;
`endif
            inp = d; inv_b = iv; in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         hs_in = in_valid && in_ready;
         hs_out = out_valid && out_ready;
         res_s = res;
         @(posedge clk); #1;
         cyc++;
         if (hs_in) begin
            q.push_back(sub_state(inp, inv_b));
            sent++;
            in_valid = 1'b0;
         end
         if (hs_out) begin
            got++;
            if (q.size() == 0) begin
               chk("rnd_unexpected_output", 128'd0, 128'd1);
            end else begin
               e = q.pop_front();
               chk("rnd_res", res_s, e);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("rnd_count", 128'(got), 128'd1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
